// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and the round-robin scan used by the FIFO write-port arbiter.
// Requester vectors are zero-extended to MAX_REQ so one function serves every NUM_REQ.
package fifo_ctrl_pkg;

   localparam int BURST_W   = 4;
   localparam int MAX_REQ   = 8;
   localparam int MAX_IDX_W = 3;

   typedef enum logic {IDLE, GRANT} arb_state_t;

   typedef struct packed {
      logic                 found;
      logic [MAX_IDX_W-1:0] idx;
   } pick_t;

   // Scan from farthest to nearest so the first requester after 'last' overwrites the rest.
   function automatic pick_t rr_pick(input logic [MAX_REQ-1:0]   req,
                                     input logic [MAX_IDX_W-1:0] last,
                                     input int                   num_req);
      pick_t p;
      int    k;
      p = '0;
      for (int i = MAX_REQ; i >= 1; i--) begin
         if (i <= num_req) begin
            k = (int'(last) + i) % num_req;
            if (req[k[MAX_IDX_W-1:0]]) begin
               p.found = 1'b1;
               p.idx   = k[MAX_IDX_W-1:0];
            end
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester and FIFO-write bundle of the arbiter; master is the arbiter side.
interface fifo_wr_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_LINES = 8
);
   localparam int IDX_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]            req;
   logic [NUM_REQ*DATA_LINES-1:0] req_data;
   logic [NUM_REQ-1:0]            ack;
   logic                          wfull;
   logic                          half_full;
   logic                          winc;
   logic [DATA_LINES-1:0]         wdata;
   logic [IDX_W-1:0]              owner;
   logic                          busy;

   modport master (input req, req_data, wfull, half_full,
                   output ack, winc, wdata, owner, busy);
   modport slave  (output req, req_data, wfull, half_full,
                   input ack, winc, wdata, owner, busy);
endinterface

// File: rtl/fifo_wr_arbiter_picker.sv
// Combinational round-robin priority encoder: first set request after i_last, wrapping.
module rr_picker
   import fifo_ctrl_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_last,
   output logic               o_found,
   output logic [IDX_W-1:0]   o_idx
);

   logic [MAX_REQ-1:0] w_req_ext;
   pick_t              w_pick;

   always_comb begin
      w_req_ext              = '0;
      w_req_ext[NUM_REQ-1:0] = i_req;
   end

   assign w_pick  = rr_pick(w_req_ext, MAX_IDX_W'(i_last), NUM_REQ);
   assign o_found = w_pick.found;
   assign o_idx   = w_pick.idx[IDX_W-1:0];

   if (IDX_W < MAX_IDX_W) begin : g_narrow
      logic w_unused;
      assign w_unused = ^w_pick.idx[MAX_IDX_W-1:IDX_W];
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin owner of the FIFO write port: bursts of up to MAX_BURST words, 1 word
// while half_full; first write one cycle after req; stalls in place on wfull.
module fifo_wr_arbiter
   import fifo_ctrl_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_LINES = 8,
   parameter int MAX_BURST  = 4
) (
   input  logic               wclk,
   input  logic               wrst,
   fifo_wr_arbiter_if.master  bus
);

   localparam int IDX_W = $clog2(NUM_REQ);

   arb_state_t           r_state, w_state_nxt;
   logic [IDX_W-1:0]     r_owner, w_owner_nxt;
   logic [IDX_W-1:0]     r_last, w_last_nxt;
   logic [BURST_W-1:0]   r_burst_cnt, w_burst_nxt;
   logic [IDX_W-1:0]     w_pick_last, w_pick_idx;
   logic                 w_pick_found;
   logic [BURST_W-1:0]   w_cnt_inc, w_limit;
   logic                 w_xfer, w_burst_end;
   logic                 w_winc, w_busy;
   logic [NUM_REQ-1:0]   w_ack;
   logic [DATA_LINES-1:0] w_wdata;

   // In GRANT the current owner becomes lowest priority, so one picker covers both paths.
   assign w_pick_last = (r_state == GRANT) ? r_owner : r_last;

   rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
      .i_req   (bus.req),
      .i_last  (w_pick_last),
      .o_found (w_pick_found),
      .o_idx   (w_pick_idx)
   );

   assign w_xfer      = (r_state == GRANT) && bus.req[r_owner] && !bus.wfull;
   assign w_limit     = bus.half_full ? BURST_W'(1) : BURST_W'(MAX_BURST);
   assign w_cnt_inc   = r_burst_cnt + BURST_W'(1);
   assign w_burst_end = w_xfer && (w_cnt_inc >= w_limit);

   always_ff @(posedge wclk) begin
      if (wrst) begin
         r_state     <= IDLE;
         r_owner     <= '0;
         r_last      <= IDX_W'(NUM_REQ - 1);
         r_burst_cnt <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_owner     <= w_owner_nxt;
         r_last      <= w_last_nxt;
         r_burst_cnt <= w_burst_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_owner_nxt = r_owner;
      w_last_nxt  = r_last;
      w_burst_nxt = r_burst_cnt;
      case (r_state)
         IDLE: begin
            if (w_pick_found) begin
               w_state_nxt = GRANT;
               w_owner_nxt = w_pick_idx;
               w_burst_nxt = '0;
            end
         end
         GRANT: begin
            // A withdrawn request ends the burst just like reaching the limit.
            if (w_burst_end || !bus.req[r_owner]) begin
               w_last_nxt  = r_owner;
               w_burst_nxt = '0;
               if (w_pick_found) w_owner_nxt = w_pick_idx;
               else              w_state_nxt = IDLE;
            end else if (w_xfer) begin
               w_burst_nxt = w_cnt_inc;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      w_winc  = 1'b0;
      w_ack   = '0;
      w_wdata = '0;
      w_busy  = 1'b0;
      if (r_state == GRANT) begin
         w_busy  = 1'b1;
         w_wdata = bus.req_data[r_owner*DATA_LINES +: DATA_LINES];
         if (w_xfer && !wrst) begin
            w_winc         = 1'b1;
            w_ack[r_owner] = 1'b1;
         end
      end
   end

   assign bus.winc  = w_winc;
   assign bus.ack   = w_ack;
   assign bus.wdata = w_wdata;
   assign bus.owner = r_owner;
   assign bus.busy  = w_busy;

endmodule
